// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: register file, two bypassed read ports, op2 mux and
// the decode/execute latch with stall (hold) and flush (bubble).
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   in_valid         decode slot holds a real instruction
//   src_addr         operand 1 register
//   dst_addr         operand 2 / store-data register
//   use_imm, imm     select imm instead of regs[dst_addr] for alu_input2
//   stall, flush     hold latch / insert bubble (flush wins)
//   write_back,
//   write_addr,
//   write_data       register file write port from write-back
//   out_valid, read_data1, alu_input2,
//   store_data, out_dst_addr   latched decode/execute bundle
module decode_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic              use_imm,
  input  logic [DATA_W-1:0] imm,
  input  logic              stall,
  input  logic              flush,
  input  logic              write_back,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] alu_input2,
  output logic [DATA_W-1:0] store_data,
  output logic [ADDR_W-1:0] out_dst_addr
);

  localparam int NREGS = 1 << ADDR_W;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] st;
    logic [ADDR_W-1:0] dst;
  } id_ex_t;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  id_ex_t            nxt;
  id_ex_t            lat;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (write_back) begin
      regs[write_addr] <= write_data;
    end
  end

  // Same-cycle write-back is forwarded so the latch never sees stale data
  always_comb begin
    rd1 = regs[src_addr];
    rd2 = regs[dst_addr];
    if (write_back && write_addr == src_addr)
      rd1 = write_data;
    if (write_back && write_addr == dst_addr)
      rd2 = write_data;
  end

  always_comb begin
    nxt.vld = in_valid;
    nxt.rd1 = rd1;
    nxt.op2 = use_imm ? imm : rd2;
    nxt.st  = rd2;
    nxt.dst = dst_addr;
  end

  always_ff @(posedge clk) begin
    if (reset)
      lat <= '0;
    else if (flush)
      lat <= '0;
    else if (!stall)
      lat <= nxt;
  end

  assign out_valid    = lat.vld;
  assign read_data1   = lat.rd1;
  assign alu_input2   = lat.op2;
  assign store_data   = lat.st;
  assign out_dst_addr = lat.dst;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed + random checks of decode_stage_pipe
// against a behavioural model; second instance covers 32-bit x 16 regs.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, use_imm, stall, flush, write_back;
  logic [2:0]  src_addr, dst_addr, write_addr;
  logic [15:0] imm, write_data;
  logic        out_valid;
  logic [15:0] read_data1, alu_input2, store_data;
  logic [2:0]  out_dst_addr;

  decode_stage_pipe #(.DATA_W(16), .ADDR_W(3)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .src_addr(src_addr), .dst_addr(dst_addr),
    .use_imm(use_imm), .imm(imm),
    .stall(stall), .flush(flush),
    .write_back(write_back), .write_addr(write_addr),
    .write_data(write_data),
    .out_valid(out_valid), .read_data1(read_data1),
    .alu_input2(alu_input2), .store_data(store_data),
    .out_dst_addr(out_dst_addr)
  );

  logic        w_reset, w_in_valid, w_use_imm, w_stall, w_flush, w_wb;
  logic [3:0]  w_src, w_dst, w_wa;
  logic [31:0] w_imm, w_wd;
  logic        w_vld;
  logic [31:0] w_rd1, w_op2, w_st;
  logic [3:0]  w_odst;

  decode_stage_pipe #(.DATA_W(32), .ADDR_W(4)) u_dut_w (
    .clk(clk), .reset(w_reset), .in_valid(w_in_valid),
    .src_addr(w_src), .dst_addr(w_dst),
    .use_imm(w_use_imm), .imm(w_imm),
    .stall(w_stall), .flush(w_flush),
    .write_back(w_wb), .write_addr(w_wa),
    .write_data(w_wd),
    .out_valid(w_vld), .read_data1(w_rd1),
    .alu_input2(w_op2), .store_data(w_st),
    .out_dst_addr(w_odst)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: architectural registers + expected latch
  logic [15:0] m_regs [8];
  logic        m_vld;
  logic [15:0] m_rd1, m_op2, m_st;
  logic [2:0]  m_dst;

  task automatic step();
    logic [15:0] r1, r2;
    r1 = m_regs[src_addr];
    r2 = m_regs[dst_addr];
    if (write_back && write_addr == src_addr) r1 = write_data;
    if (write_back && write_addr == dst_addr) r2 = write_data;
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      {m_vld, m_rd1, m_op2, m_st, m_dst} = '0;
    end else begin
      if (flush)
        {m_vld, m_rd1, m_op2, m_st, m_dst} = '0;
      else if (!stall) begin
        m_vld = in_valid;
        m_rd1 = r1;
        m_op2 = use_imm ? imm : r2;
        m_st  = r2;
        m_dst = dst_addr;
      end
      if (write_back) m_regs[write_addr] = write_data;
    end
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
    chk("read_data1", {16'd0, read_data1}, {16'd0, m_rd1});
    chk("alu_input2", {16'd0, alu_input2}, {16'd0, m_op2});
    chk("store_data", {16'd0, store_data}, {16'd0, m_st});
    chk("out_dst_addr", {29'd0, out_dst_addr}, {29'd0, m_dst});
  endtask

  function automatic logic [31:0] wval(input int i);
    return (i == 15) ? 32'hDEADBEEF : 32'h01010101 * (i + 1);
  endfunction

  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    {m_vld, m_rd1, m_op2, m_st, m_dst} = '0;
    {w_in_valid, w_use_imm, w_stall, w_flush, w_wb} = '0;
    {w_src, w_dst, w_wa, w_imm, w_wd} = '0;
    w_reset = 1'b1;

    // Reset with a pending write: write must be suppressed
    reset = 1; in_valid = 0; use_imm = 0; stall = 0; flush = 0;
    src_addr = 0; dst_addr = 0; imm = 0;
    write_back = 1; write_addr = 3; write_data = 16'hFFFF;
    step();
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rd1", {16'd0, read_data1}, 32'd0);
    reset = 0; write_back = 0; src_addr = 3; in_valid = 1;
    step();
    chk("rst_r3", {16'd0, read_data1}, 32'd0);

    // Write then read through the array
    in_valid = 0;
    write_back = 1; write_addr = 2; write_data = 16'h1234;
    step();
    write_back = 0; src_addr = 2; dst_addr = 2; in_valid = 1;
    step();
    chk("wr_rd1", {16'd0, read_data1}, 32'h1234);
    chk("wr_op2", {16'd0, alu_input2}, 32'h1234);
    chk("wr_st", {16'd0, store_data}, 32'h1234);
    chk("wr_vld", {31'd0, out_valid}, 32'd1);

    // Bypass beats stale array value
    write_back = 1; write_addr = 5; write_data = 16'h0001;
    step();
    write_data = 16'hBEEF; src_addr = 5;
    step();
    chk("bypass", {16'd0, read_data1}, 32'hBEEF);

    // Immediate select; store_data still the register
    write_addr = 1; write_data = 16'h00AA;
    step();
    write_back = 0; dst_addr = 1; use_imm = 1; imm = 16'hFFF0;
    step();
    chk("imm_op2", {16'd0, alu_input2}, 32'hFFF0);
    chk("imm_st", {16'd0, store_data}, 32'h00AA);

    // Stall holds despite input changes and write-backs
    use_imm = 0; src_addr = 2; dst_addr = 2;
    step();
    stall = 1;
    repeat (3) begin
      src_addr = 3'($urandom); dst_addr = 3'($urandom);
      imm = 16'($urandom); in_valid = 1'($urandom);
      write_back = 1; write_addr = 2; write_data = 16'($urandom);
      step();
    end
    chk("stall_rd1", {16'd0, read_data1}, 32'h1234);
    write_back = 0; flush = 1;
    step();
    chk("flush_vld", {31'd0, out_valid}, 32'd0);
    chk("flush_rd1", {16'd0, read_data1}, 32'd0);

    // Reset mid-stall
    flush = 0; in_valid = 1;
    step();
    reset = 1;
    step();
    reset = 0; stall = 0;

    // Random traffic
    repeat (400) begin
      reset      = ($urandom_range(63) == 0);
      flush      = ($urandom_range(15) == 0);
      stall      = ($urandom_range(7) == 0);
      write_back = 1'($urandom);
      in_valid   = 1'($urandom);
      use_imm    = 1'($urandom);
      src_addr   = 3'($urandom);
      dst_addr   = 3'($urandom);
      write_addr = 3'($urandom);
      imm        = 16'($urandom);
      write_data = 16'($urandom);
      step();
    end

    // Wide instance: every register independently addressable
    @(posedge clk); #1;
    chk("w_rst_vld", {31'd0, w_vld}, 32'd0);
    chk("w_rst_rd1", w_rd1, 32'd0);
    w_reset = 0; w_wb = 1;
    for (int i = 0; i < 16; i++) begin
      w_wa = 4'(i); w_wd = wval(i);
      @(posedge clk); #1;
    end
    w_wb = 0; w_in_valid = 1;
    for (int i = 0; i < 16; i++) begin
      w_src = 4'(i); w_dst = 4'(15 - i);
      @(posedge clk); #1;
      chk("w_rd1", w_rd1, wval(i));
      chk("w_st", w_st, wval(15 - i));
      chk("w_op2", w_op2, wval(15 - i));
      chk("w_odst", {28'd0, w_odst}, 32'(15 - i));
    end
    w_src = 4'd15;
    @(posedge clk); #1;
    chk("w_r15", w_rd1, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
